hazard_pipe_tracker: RTL
========================

Name: hazard_pipe_tracker

Overview:
- Producer end of the operand-forwarding interface.
- Carries decoded register-usage fields for each instruction from ID through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Drives the rs/rd/RegWrite signals that the forwarding unit consumes.
- Detects load-use hazards that forwarding cannot resolve, stalls the front end and injects bubbles. Also injects bubbles on branch flush and keeps saturating event counters.

Parameters:
- REG_W, 5, register-address width.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_W  first source register of the ID instruction.
- id_rs2  in  REG_W  second source register of the ID instruction.
- id_uses_rs2  in  1  id_rs2 is a true source; 0 for I-type.
- id_rd  in  REG_W  destination register of the ID instruction.
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- flush  in  1  branch resolved taken; kill the ID instruction this cycle.
- stall  out  1  hold PC and IF/ID; combinational.
- rs1_ID_EX  out  REG_W  registered.
- rs2_ID_EX  out  REG_W  registered.
- rd_ID_EX  out  REG_W  registered.
- MemRead_ID_EX  out  1  registered.
- RegWrite_ID_EX  out  1  registered.
- rd_EX_MEM  out  REG_W  registered.
- RegWrite_EX_MEM  out  1  registered.
- rd_MEM_WB  out  REG_W  registered.
- RegWrite_MEM_WB  out  1  registered.
- stall_cnt  out  CNT_W  number of stall cycles, saturating.
- flush_cnt  out  CNT_W  number of flush cycles, saturating.

Behaviour:
- Reset: on the clk edge with rst=1, every registered output and both counters become 0, so stall=0. rst overrides all other inputs, including mid-stall and mid-flush. The next instruction after reset release enters cleanly.
- Hazard term:
  - haz = id_valid & MemRead_ID_EX & RegWrite_ID_EX & (rd_ID_EX != 0) & ((rd_ID_EX == id_rs1) | (id_uses_rs2 & rd_ID_EX == id_rs2)).
  - stall = haz & ~flush. It is purely combinational from the current state and the ID inputs, with no extra latency.
- Bubble definition: rs1, rs2 and rd = 0; MemRead = 0; RegWrite = 0.
- ID/EX update, every clk edge, in priority order:
  - (1) flush=1: load a bubble; flush_cnt += 1.
  - (2) stall=1: load a bubble; stall_cnt += 1.
  - (3) id_valid=0: load a bubble.
  - (4) Otherwise capture the ID fields. RegWrite = id_reg_write & (id_rd != 0). MemRead = id_mem_read. rs2 is captured as 0 when id_uses_rs2=0.
- EX/MEM and MEM/WB: always advance, never stalled or flushed by this block.
  - rd_EX_MEM <= rd_ID_EX; RegWrite_EX_MEM <= RegWrite_ID_EX.
  - rd_MEM_WB <= rd_EX_MEM; RegWrite_MEM_WB <= RegWrite_EX_MEM.
- Latency: a field captured at edge N appears on the *_ID_EX outputs after N, *_EX_MEM after N+1 and *_MEM_WB after N+2.
- Stall length: a load-use hazard always costs exactly 1 cycle. The bubble clears MemRead_ID_EX, so haz drops on the following cycle while the upstream stage holds the same ID fields.
- No stall for ALU-to-ALU dependencies; these are left to forwarding.
- No stall when the load targets r0, when rd matches only rs2 with id_uses_rs2=0, or when id_valid=0.
- flush and haz together: flush wins, stall=0, only flush_cnt increments.
- Counters: saturate at all-ones and hold there; they never wrap.

Test Plan:
- Reset with rst=1 for 2 cycles, then drive an add r5←r1,r2: all outputs 0 during reset. One cycle after release, rd_ID_EX=5 and RegWrite_ID_EX=1. After 2 more edges, rd_MEM_WB=5 and RegWrite_MEM_WB=1. stall=0 throughout.
- Drive lw r5 followed by add r6←r5,r3 (uses_rs2=1): stall=1 for exactly 1 cycle and the ID/EX bubble has all fields 0. The next cycle captures rs1_ID_EX=5. rd_EX_MEM=5 with MemRead path intact. stall_cnt=1.
- Repeat the lw with an addi consumer (uses_rs2=0), rs1=7, rs2 field=5: stall=0. Repeat with lw r0 followed by a consumer of r0: stall=0, and RegWrite_ID_EX=0 for the lw.
- lw r5 hazard with flush=1 in the same cycle: stall=0, ID/EX gets a bubble, flush_cnt=1, stall_cnt unchanged.
- Assert rst on the stall cycle of a load-use: the next edge zeroes all state and stall=0 afterwards.
- CNT_W=2 with 5 separate load-use hazards: stall_cnt goes 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/hazard_pipe_tracker.sv
// Register-usage tracker for the ID/EX, EX/MEM and MEM/WB stages.
// It detects load-use hazards, inserts bubbles on stall and flush, and counts both kinds of event.
module hazard_pipe_tracker #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic             stall,
    output logic [REG_W-1:0] rs1_ID_EX,
    output logic [REG_W-1:0] rs2_ID_EX,
    output logic [REG_W-1:0] rd_ID_EX,
    output logic             MemRead_ID_EX,
    output logic             RegWrite_ID_EX,
    output logic [REG_W-1:0] rd_EX_MEM,
    output logic             RegWrite_EX_MEM,
    output logic [REG_W-1:0] rd_MEM_WB,
    output logic             RegWrite_MEM_WB,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             haz;
    logic             bubble;
    logic [REG_W-1:0] rs1_next;
    logic [REG_W-1:0] rs2_next;
    logic [REG_W-1:0] rd_next;
    logic             mem_read_next;
    logic             reg_write_next;
    logic [CNT_W-1:0] stall_cnt_next;
    logic [CNT_W-1:0] flush_cnt_next;

    // Only a load still sitting in ID/EX cannot be forwarded in time.
    // A write to r0 is not a real write, so it never creates a hazard.
    always_comb begin
        haz = id_valid & MemRead_ID_EX & RegWrite_ID_EX & (rd_ID_EX != '0) &
              ((rd_ID_EX == id_rs1) | (id_uses_rs2 & (rd_ID_EX == id_rs2)));
        stall = haz & ~flush;
    end

    always_comb begin
        bubble         = flush | stall | ~id_valid;
        rs1_next       = '0;
        rs2_next       = '0;
        rd_next        = '0;
        mem_read_next  = 1'b0;
        reg_write_next = 1'b0;
        if (!bubble) begin
            rs1_next       = id_rs1;
            rs2_next       = id_uses_rs2 ? id_rs2 : '0;
            rd_next        = id_rd;
            mem_read_next  = id_mem_read;
            reg_write_next = id_reg_write & (id_rd != '0);
        end
    end

    // Both counters saturate at all-ones. A flush masks stall, so they never step together.
    always_comb begin
        stall_cnt_next = stall_cnt;
        flush_cnt_next = flush_cnt;
        if (flush && (flush_cnt != '1)) begin
            flush_cnt_next = flush_cnt + 1'b1;
        end
        if (stall && (stall_cnt != '1)) begin
            stall_cnt_next = stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_ID_EX       <= '0;
            rs2_ID_EX       <= '0;
            rd_ID_EX        <= '0;
            MemRead_ID_EX   <= 1'b0;
            RegWrite_ID_EX  <= 1'b0;
            rd_EX_MEM       <= '0;
            RegWrite_EX_MEM <= 1'b0;
            rd_MEM_WB       <= '0;
            RegWrite_MEM_WB <= 1'b0;
            stall_cnt       <= '0;
            flush_cnt       <= '0;
        end else begin
            rs1_ID_EX       <= rs1_next;
            rs2_ID_EX       <= rs2_next;
            rd_ID_EX        <= rd_next;
            MemRead_ID_EX   <= mem_read_next;
            RegWrite_ID_EX  <= reg_write_next;
            rd_EX_MEM       <= rd_ID_EX;
            RegWrite_EX_MEM <= RegWrite_ID_EX;
            rd_MEM_WB       <= rd_EX_MEM;
            RegWrite_MEM_WB <= RegWrite_EX_MEM;
            stall_cnt       <= stall_cnt_next;
            flush_cnt       <= flush_cnt_next;
        end
    end

endmodule
